// File: rtl/rob_forward_source.sv
// In-order reorder buffer feeding the operand bypass checker: allocate by decode,
// complete by tag, commit in order, and expose two youngest-producer lookup ports.
module rob_forward_source #(
   parameter int ARCH_BITS    = 32,
   parameter int REG_IDX_BITS = 5,
   parameter int ENTRIES      = 8,
   parameter int TAG_BITS     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    alloc_valid,
   input  logic [REG_IDX_BITS-1:0] alloc_dst,
   output logic                    alloc_ready,
   output logic [TAG_BITS-1:0]     alloc_tag,
   input  logic                    cmpl_valid,
   input  logic [TAG_BITS-1:0]     cmpl_tag,
   input  logic [ARCH_BITS-1:0]    cmpl_data,
   input  logic [REG_IDX_BITS-1:0] lookup_idx1,
   input  logic [REG_IDX_BITS-1:0] lookup_idx2,
   output logic                    fwd_valid1,
   output logic [ARCH_BITS-1:0]    fwd_data1,
   output logic [REG_IDX_BITS-1:0] fwd_dst1,
   output logic                    fwd_we1,
   output logic                    fwd_valid2,
   output logic [ARCH_BITS-1:0]    fwd_data2,
   output logic [REG_IDX_BITS-1:0] fwd_dst2,
   output logic                    fwd_we2,
   output logic                    commit_valid,
   output logic [REG_IDX_BITS-1:0] commit_dst,
   output logic [ARCH_BITS-1:0]    commit_data,
   output logic [TAG_BITS:0]       count
);

   logic [ENTRIES-1:0]      busy_q;
   logic [ENTRIES-1:0]      done_q;
   logic [REG_IDX_BITS-1:0] dst_q  [ENTRIES];
   logic [ARCH_BITS-1:0]    data_q [ENTRIES];
   logic [TAG_BITS-1:0]     head_q;
   logic [TAG_BITS-1:0]     tail_q;
   logic [TAG_BITS:0]       count_q;
   logic                    commit_valid_q;
   logic [REG_IDX_BITS-1:0] commit_dst_q;
   logic [ARCH_BITS-1:0]    commit_data_q;

   logic alloc_fire;
   logic cmpl_fire;
   logic commit_fire;

   // Handshake: an allocation transfers on a rising edge where alloc_valid and
   // alloc_ready are both high; alloc_ready depends only on registered count.
   assign alloc_ready = (count_q < (TAG_BITS+1)'(ENTRIES));
   assign alloc_tag   = tail_q;
   assign count       = count_q;

   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign cmpl_fire   = cmpl_valid && busy_q[cmpl_tag] && !flush;
   // Uses pre-edge done, so a same-cycle completion commits one cycle later.
   assign commit_fire = (count_q != '0) && busy_q[head_q] && done_q[head_q] && !flush;

   assign commit_valid = commit_valid_q;
   assign commit_dst   = commit_dst_q;
   assign commit_data  = commit_data_q;

   // Walk oldest to youngest so the last hit (the youngest producer) wins.
   function automatic logic [ARCH_BITS+1:0] search(input logic [REG_IDX_BITS-1:0] idx);
      logic [ARCH_BITS+1:0] res;
      logic [TAG_BITS-1:0]  pos;
      res = {1'b0, 1'b0, {ARCH_BITS{1'b1}}};
      for (int i = 0; i < ENTRIES; i++) begin
         pos = head_q + TAG_BITS'(i);
         if (((TAG_BITS+1)'(i) < count_q) && busy_q[pos] && (dst_q[pos] == idx)) begin
            res = {1'b1, done_q[pos], done_q[pos] ? data_q[pos] : {ARCH_BITS{1'b1}}};
         end
      end
      return res;
   endfunction

   always_comb begin
      {fwd_valid1, fwd_we1, fwd_data1} = search(lookup_idx1);
      {fwd_valid2, fwd_we2, fwd_data2} = search(lookup_idx2);
      fwd_dst1 = lookup_idx1;
      fwd_dst2 = lookup_idx2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q         <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_dst_q   <= '0;
         commit_data_q  <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            dst_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         busy_q         <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
      end else begin
         if (cmpl_fire) begin
            done_q[cmpl_tag] <= 1'b1;
            data_q[cmpl_tag] <= cmpl_data;
         end
         if (commit_fire) begin
            busy_q[head_q] <= 1'b0;
            head_q         <= head_q + 1'b1;
            commit_valid_q <= 1'b1;
            commit_dst_q   <= dst_q[head_q];
            commit_data_q  <= data_q[head_q];
         end else begin
            commit_valid_q <= 1'b0;
         end
         // Allocation never targets a busy slot: it is blocked whenever full.
         if (alloc_fire) begin
            busy_q[tail_q] <= 1'b1;
            done_q[tail_q] <= 1'b0;
            dst_q[tail_q]  <= alloc_dst;
            tail_q         <= tail_q + 1'b1;
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_rob_forward_source.sv
// Directed bench for rob_forward_source: allocation, completion, in-order commit,
// youngest-producer lookup, full/wrap, flush and asynchronous reset.
module tb_rob_forward_source;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        alloc_valid;
   logic [4:0]  alloc_dst;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cmpl_valid;
   logic [2:0]  cmpl_tag;
   logic [31:0] cmpl_data;
   logic [4:0]  lookup_idx1;
   logic [4:0]  lookup_idx2;
   logic        fwd_valid1;
   logic [31:0] fwd_data1;
   logic [4:0]  fwd_dst1;
   logic        fwd_we1;
   logic        fwd_valid2;
   logic [31:0] fwd_data2;
   logic [4:0]  fwd_dst2;
   logic        fwd_we2;
   logic        commit_valid;
   logic [4:0]  commit_dst;
   logic [31:0] commit_data;
   logic [3:0]  count;

   int checks;
   int passed;

   rob_forward_source dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_dst(alloc_dst),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
      .lookup_idx1(lookup_idx1), .lookup_idx2(lookup_idx2),
      .fwd_valid1(fwd_valid1), .fwd_data1(fwd_data1), .fwd_dst1(fwd_dst1), .fwd_we1(fwd_we1),
      .fwd_valid2(fwd_valid2), .fwd_data2(fwd_data2), .fwd_dst2(fwd_dst2), .fwd_we2(fwd_we2),
      .commit_valid(commit_valid), .commit_dst(commit_dst), .commit_data(commit_data),
      .count(count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic alloc(input logic [4:0] dst);
      alloc_valid = 1'b1; alloc_dst = dst;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; lookup_idx1 = 5'd5; lookup_idx2 = 5'd0;
      #2;
      checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
      checks++; if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); else passed++;
      checks++; if ({commit_dst, commit_data} !== 37'd0) $display("FAIL reset_commit_payload: got %h/%h expected 0/0", commit_dst, commit_data); else passed++;
      checks++; if ({alloc_ready, alloc_tag} !== 4'b1_000) $display("FAIL reset_alloc: got ready=%b tag=%0d expected 1/0", alloc_ready, alloc_tag); else passed++;
      checks++; if ({fwd_valid1, fwd_we1, fwd_data1} !== {2'b00, 32'hFFFF_FFFF}) $display("FAIL reset_lookup: got v=%b we=%b d=%h expected 0/0/ffffffff", fwd_valid1, fwd_we1, fwd_data1); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_alloc_complete_commit();
      alloc_valid = 1'b1; alloc_dst = 5'd5;
      #1;
      checks++; if (alloc_tag !== 3'd0) $display("FAIL first_alloc_tag: got %0d expected 0", alloc_tag); else passed++;
      tick();
      alloc_valid = 1'b0; lookup_idx1 = 5'd5;
      #1;
      checks++; if (count !== 4'd1) $display("FAIL alloc_count: got %0d expected 1", count); else passed++;
      checks++; if ({fwd_valid1, fwd_we1, fwd_data1, fwd_dst1} !== {2'b10, 32'hFFFF_FFFF, 5'd5}) $display("FAIL pending_lookup: got v=%b we=%b d=%h dst=%0d expected 1/0/ffffffff/5", fwd_valid1, fwd_we1, fwd_data1, fwd_dst1); else passed++;
      cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h1234;
      tick();
      cmpl_valid = 1'b0;
      #1;
      checks++; if ({fwd_valid1, fwd_we1, fwd_data1} !== {2'b11, 32'h1234}) $display("FAIL done_lookup: got v=%b we=%b d=%h expected 1/1/00001234", fwd_valid1, fwd_we1, fwd_data1); else passed++;
      checks++; if (commit_valid !== 1'b0) $display("FAIL no_chain_commit: got %b expected 0", commit_valid); else passed++;
      tick();
      checks++; if ({commit_valid, commit_dst, commit_data} !== {1'b1, 5'd5, 32'h1234}) $display("FAIL first_commit: got v=%b dst=%0d d=%h expected 1/5/00001234", commit_valid, commit_dst, commit_data); else passed++;
      checks++; if (count !== 4'd0) $display("FAIL commit_count: got %0d expected 0", count); else passed++;
      checks++; if (fwd_valid1 !== 1'b0) $display("FAIL lookup_after_commit: got %b expected 0", fwd_valid1); else passed++;
   endtask

   task automatic test_youngest_wins();
      do_reset();
      alloc(5'd3);
      alloc(5'd3);
      cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'hAA;
      tick();
      cmpl_valid = 1'b0; lookup_idx1 = 5'd3; lookup_idx2 = 5'd7;
      #1;
      checks++; if ({fwd_valid1, fwd_we1, fwd_data1} !== {2'b10, 32'hFFFF_FFFF}) $display("FAIL youngest_lookup: got v=%b we=%b d=%h expected 1/0/ffffffff", fwd_valid1, fwd_we1, fwd_data1); else passed++;
      checks++; if ({fwd_valid2, fwd_we2, fwd_data2, fwd_dst2} !== {2'b00, 32'hFFFF_FFFF, 5'd7}) $display("FAIL port2_miss: got v=%b we=%b d=%h dst=%0d expected 0/0/ffffffff/7", fwd_valid2, fwd_we2, fwd_data2, fwd_dst2); else passed++;
      tick();
      checks++; if ({commit_valid, commit_dst, commit_data} !== {1'b1, 5'd3, 32'hAA}) $display("FAIL older_commit: got v=%b dst=%0d d=%h expected 1/3/000000aa", commit_valid, commit_dst, commit_data); else passed++;
      checks++; if ({fwd_valid1, fwd_we1, count} !== {2'b10, 4'd1}) $display("FAIL younger_remains: got v=%b we=%b cnt=%0d expected 1/0/1", fwd_valid1, fwd_we1, count); else passed++;
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         alloc_valid = 1'b1; alloc_dst = 5'(i);
         #1;
         checks++; if (alloc_tag !== 3'(i)) $display("FAIL fill_tag_%0d: got %0d expected %0d", i, alloc_tag, i); else passed++;
         tick();
      end
      alloc_dst = 5'd9;
      checks++; if ({count, alloc_ready} !== {4'd8, 1'b0}) $display("FAIL full_state: got cnt=%0d ready=%b expected 8/0", count, alloc_ready); else passed++;
      tick();
      checks++; if ({count, alloc_tag} !== {4'd8, 3'd0}) $display("FAIL ninth_ignored: got cnt=%0d tag=%0d expected 8/0", count, alloc_tag); else passed++;
      cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h100;
      tick();
      cmpl_valid = 1'b0;
      tick();
      checks++; if ({commit_valid, commit_dst, commit_data} !== {1'b1, 5'd0, 32'h100}) $display("FAIL full_commit: got v=%b dst=%0d d=%h expected 1/0/00000100", commit_valid, commit_dst, commit_data); else passed++;
      checks++; if ({count, alloc_ready, alloc_tag} !== {4'd7, 1'b1, 3'd0}) $display("FAIL no_alloc_on_full_commit: got cnt=%0d ready=%b tag=%0d expected 7/1/0", count, alloc_ready, alloc_tag); else passed++;
      tick();
      alloc_valid = 1'b0; lookup_idx1 = 5'd9; lookup_idx2 = 5'd0;
      #1;
      checks++; if ({count, alloc_ready, alloc_tag} !== {4'd8, 1'b0, 3'd1}) $display("FAIL wrap_alloc: got cnt=%0d ready=%b tag=%0d expected 8/0/1", count, alloc_ready, alloc_tag); else passed++;
      checks++; if ({fwd_valid1, fwd_we1, fwd_valid2} !== 3'b100) $display("FAIL wrap_lookup: got v1=%b we1=%b v2=%b expected 1/0/0", fwd_valid1, fwd_we1, fwd_valid2); else passed++;
   endtask

   task automatic test_out_of_order();
      logic [4:0]  exp_dst [3];
      logic [31:0] exp_data [3];
      exp_dst = '{5'd10, 5'd11, 5'd12};
      exp_data = '{32'h30, 32'h11, 32'h22};
      do_reset();
      alloc(5'd10);
      alloc(5'd11);
      alloc(5'd12);
      cmpl_valid = 1'b1; cmpl_tag = 3'd2; cmpl_data = 32'h22;
      tick();
      cmpl_tag = 3'd1; cmpl_data = 32'h11;
      tick();
      lookup_idx1 = 5'd12;
      #1;
      checks++; if ({fwd_valid1, fwd_we1, fwd_data1, commit_valid} !== {2'b11, 32'h22, 1'b0}) $display("FAIL ooo_blocked: got v=%b we=%b d=%h cv=%b expected 1/1/00000022/0", fwd_valid1, fwd_we1, fwd_data1, commit_valid); else passed++;
      cmpl_tag = 3'd0; cmpl_data = 32'h30;
      tick();
      cmpl_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({commit_valid, commit_dst, commit_data} !== {1'b1, exp_dst[i], exp_data[i]}) $display("FAIL inorder_commit_%0d: got v=%b dst=%0d d=%h expected 1/%0d/%h", i, commit_valid, commit_dst, commit_data, exp_dst[i], exp_data[i]); else passed++;
      end
      cmpl_valid = 1'b1; cmpl_tag = 3'd5; cmpl_data = 32'hDEAD;
      tick();
      cmpl_valid = 1'b0;
      tick();
      checks++; if ({commit_valid, commit_dst, commit_data, count} !== {1'b0, 5'd12, 32'h22, 4'd0}) $display("FAIL idle_hold: got v=%b dst=%0d d=%h cnt=%0d expected 0/12/00000022/0", commit_valid, commit_dst, commit_data, count); else passed++;
      checks++; if ({fwd_valid1, alloc_tag} !== {1'b0, 3'd3}) $display("FAIL free_cmpl_ignored: got v=%b tag=%0d expected 0/3", fwd_valid1, alloc_tag); else passed++;
   endtask

   task automatic test_flush_and_async_reset();
      do_reset();
      for (int i = 1; i <= 4; i++) alloc(5'(i));
      cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h77;
      tick();
      flush = 1'b1; alloc_valid = 1'b1; alloc_dst = 5'd7; cmpl_tag = 3'd1;
      tick();
      flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0;
      lookup_idx1 = 5'd1; lookup_idx2 = 5'd7;
      #1;
      checks++; if ({count, commit_valid, alloc_tag} !== {4'd0, 1'b0, 3'd0}) $display("FAIL flush_state: got cnt=%0d cv=%b tag=%0d expected 0/0/0", count, commit_valid, alloc_tag); else passed++;
      checks++; if ({fwd_valid1, fwd_valid2} !== 2'b00) $display("FAIL flush_lookup: got v1=%b v2=%b expected 0/0", fwd_valid1, fwd_valid2); else passed++;
      alloc(5'd7);
      #1;
      checks++; if ({count, fwd_valid2, fwd_we2} !== {4'd1, 2'b10}) $display("FAIL post_flush_alloc: got cnt=%0d v=%b we=%b expected 1/1/0", count, fwd_valid2, fwd_we2); else passed++;
      cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h55;
      tick();
      cmpl_valid = 1'b0;
      tick();
      checks++; if ({commit_valid, commit_dst, commit_data} !== {1'b1, 5'd7, 32'h55}) $display("FAIL pre_reset_commit: got v=%b dst=%0d d=%h expected 1/7/00000055", commit_valid, commit_dst, commit_data); else passed++;
      alloc(5'd2);
      alloc_valid = 1'b1; alloc_dst = 5'd7;
      #3;
      rst = 1'b0;
      #1;
      checks++; if ({count, commit_valid, commit_dst, commit_data} !== 42'd0) $display("FAIL async_reset_regs: got cnt=%0d v=%b dst=%0d d=%h expected 0/0/0/0", count, commit_valid, commit_dst, commit_data); else passed++;
      checks++; if ({alloc_ready, alloc_tag, fwd_valid1, fwd_valid2} !== 6'b1_000_00) $display("FAIL async_reset_ports: got ready=%b tag=%0d v1=%b v2=%b expected 1/0/0/0", alloc_ready, alloc_tag, fwd_valid1, fwd_valid2); else passed++;
      alloc_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      checks = 0; passed = 0;
      rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_dst = '0;
      cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0;
      lookup_idx1 = '0; lookup_idx2 = '0;
      test_reset();
      test_alloc_complete_commit();
      test_youngest_wins();
      test_full_wrap();
      test_out_of_order();
      test_flush_and_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
